// File: rtl/operand_stream_buffer_if.sv
// Handshake bundle for operand_stream_buffer: element input stream and packed-word output stream.
// Both sides use valid/ready: a transfer happens on a rising edge where valid && ready are both high.
interface operand_stream_buffer_if #(
    parameter int DATA_W = 32,
    parameter int LANES  = 2
);
    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_W-1:0]         data_in;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_W*LANES-1:0]   data_out;

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out
    );

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out
    );
endinterface

// File: rtl/operand_stream_buffer.sv
// Circular operand buffer: stores one element per cycle, emits LANES elements per packed output word.
// Optional feature macro OSB_ZERO_PAD_EN: in stream mode, flush a residue below LANES as a zero-padded word.
module operand_stream_buffer #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 16384,
    parameter  int LANES  = 2,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          state,
    operand_stream_buffer_if.slave bus,
    output logic [ADDR_W:0]     count,
    output logic                full,
    output logic                empty,
    output logic                ovf
);
    typedef enum logic [1:0] {
        MODE_IDLE   = 2'b00,
        MODE_STORE  = 2'b01,
        MODE_STREAM = 2'b10,
        MODE_PASS   = 2'b11
    } mode_e;

    mode_e mode;
    assign mode = mode_e'(state);

    logic [DATA_W-1:0]       mem [DEPTH];
    logic [ADDR_W-1:0]       wp;
    logic [ADDR_W-1:0]       rp;
    logic                    store_mode;
    logic                    stream_mode;
    logic                    push;
    logic                    out_free;
    logic                    pop_full;
    logic                    pop_part;
    logic                    pop;
    logic [ADDR_W:0]         pop_n;
    logic [ADDR_W:0]         count_nxt;
    logic [DATA_W*LANES-1:0] pop_word;

    assign store_mode  = (mode == MODE_STORE)  || (mode == MODE_PASS);
    assign stream_mode = (mode == MODE_STREAM) || (mode == MODE_PASS);

    // in_ready depends only on mode and the registered full flag
    assign bus.in_ready = store_mode && !full;
    assign push         = bus.in_valid && bus.in_ready;
    assign out_free     = !bus.out_valid || bus.out_ready;
    assign pop_full     = stream_mode && (count >= (ADDR_W+1)'(LANES)) && out_free;

`ifdef OSB_ZERO_PAD_EN
    assign pop_part = (mode == MODE_STREAM) && (count != '0) &&
                      (count < (ADDR_W+1)'(LANES)) && out_free;
`else
    assign pop_part = 1'b0;
`endif

    assign pop       = pop_full || pop_part;
    assign pop_n     = pop_full ? (ADDR_W+1)'(LANES) : (pop_part ? count : '0);
    assign count_nxt = count + (ADDR_W+1)'(push) - pop_n;

    // Oldest element lands in the most significant slice; lanes beyond pop_n stay zero.
    always_comb begin
        pop_word = '0;
        for (int i = 0; i < LANES; i++) begin
            if ((ADDR_W+1)'(i) < pop_n)
                pop_word[(LANES-1-i)*DATA_W +: DATA_W] = mem[rp + ADDR_W'(i)];
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst)
            mem[wp] <= bus.data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp            <= '0;
            rp            <= '0;
            count         <= '0;
            full          <= 1'b0;
            empty         <= 1'b1;
            ovf           <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.data_out  <= '0;
        end else begin
            if (push)
                wp <= wp + 1'b1;
            // pop_n == DEPTH only when LANES == DEPTH; its low bits are then zero, which is the correct wrap
            if (pop)
                rp <= rp + pop_n[ADDR_W-1:0];
            count <= count_nxt;
            full  <= (count_nxt == (ADDR_W+1)'(DEPTH));
            empty <= (count_nxt == '0);
            if (store_mode && bus.in_valid && full)
                ovf <= 1'b1;
            if (pop) begin
                bus.out_valid <= 1'b1;
                bus.data_out  <= pop_word;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_operand_stream_buffer.sv
// Bench for operand_stream_buffer: LANES=2/DEPTH=8 instance (table + random vs queue model) and a LANES=4 instance for residue handling.
module tb_operand_stream_buffer;
  localparam int DW = 32;
  localparam int DA = 8;
  localparam int LA = 2;
  localparam int LB = 4;
  localparam int AW = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  st_a, st_b;
  logic [AW:0] count_a, count_b;
  logic        full_a, empty_a, ovf_a;
  logic        full_b, empty_b, ovf_b;

  operand_stream_buffer_if #(.DATA_W(DW), .LANES(LA)) bus_a ();
  operand_stream_buffer_if #(.DATA_W(DW), .LANES(LB)) bus_b ();

  operand_stream_buffer #(.DATA_W(DW), .DEPTH(DA), .LANES(LA)) dut_a (
    .clk(clk), .rst(rst), .state(st_a), .bus(bus_a),
    .count(count_a), .full(full_a), .empty(empty_a), .ovf(ovf_a)
  );

  operand_stream_buffer #(.DATA_W(DW), .DEPTH(DA), .LANES(LB)) dut_b (
    .clk(clk), .rst(rst), .state(st_b), .bus(bus_b),
    .count(count_b), .full(full_b), .empty(empty_b), .ovf(ovf_b)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // table-driven vectors for instance A
  typedef struct {
    logic [1:0]  st;
    logic        iv;
    logic [31:0] din;
    logic        ordy;
    logic        exp_ir;
    logic [3:0]  exp_cnt;
    logic        exp_ov;
    logic [63:0] exp_data;
    logic        exp_ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input logic [1:0] st, input logic iv, input logic [31:0] din,
                         input logic ordy, input logic exp_ir, input logic [3:0] exp_cnt,
                         input logic exp_ov, input logic [63:0] exp_data, input logic exp_ovf);
    vec_t v;
    v.st = st; v.iv = iv; v.din = din; v.ordy = ordy; v.exp_ir = exp_ir;
    v.exp_cnt = exp_cnt; v.exp_ov = exp_ov; v.exp_data = exp_data; v.exp_ovf = exp_ovf;
    tbl.push_back(v);
  endtask

  function automatic logic [63:0] w2(input logic [31:0] hi, input logic [31:0] lo);
    return {hi, lo};
  endfunction

  // scoreboard / reference model for instance A: element queue plus output register
  logic [DW-1:0]    exp_q[$];
  logic             m_ov;
  logic [DW*LA-1:0] m_word;
  logic             m_ovf;

  task automatic idle_inputs();
    st_a = 2'b00; st_b = 2'b00;
    bus_a.in_valid = 1'b0; bus_a.data_in = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.data_in = '0; bus_b.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete(); m_ov = 1'b0; m_word = '0; m_ovf = 1'b0;
  endtask

  // driver for B: one element per cycle in store mode
  task automatic push_b(input logic [31:0] d);
    st_b = 2'b01; bus_b.in_valid = 1'b1; bus_b.data_in = d; bus_b.out_ready = 1'b0;
    @(posedge clk); #1;
    bus_b.in_valid = 1'b0;
  endtask

  // one cycle on A, checked against the model
  task automatic model_cycle(input logic [1:0] st, input logic iv, input logic [31:0] din,
                             input logic ordy, input logic r);
    int sz;
    int take;
    logic storem, streamm, pushm, freem;
    logic [DW*LA-1:0] w;
    st_a = st; bus_a.in_valid = iv; bus_a.data_in = din; bus_a.out_ready = ordy; rst = r;
    #1;
    storem  = (st == 2'b01) || (st == 2'b11);
    streamm = (st == 2'b10) || (st == 2'b11);
    sz = exp_q.size();
    check("rand_in_ready", bus_a.in_ready, storem && (sz < DA));
    if (r) begin
      exp_q.delete(); m_ov = 1'b0; m_word = '0; m_ovf = 1'b0;
    end else begin
      pushm = iv && storem && (sz < DA);
      if (iv && storem && sz == DA) m_ovf = 1'b1;
      freem = !m_ov || ordy;
      take = 0;
      if (streamm && sz >= LA && freem) take = LA;
`ifdef OSB_ZERO_PAD_EN
      else if (st == 2'b10 && sz > 0 && freem) take = sz;
`endif
      if (take > 0) begin
        w = '0;
        for (int i = 0; i < take; i++) w[(LA-1-i)*DW +: DW] = exp_q.pop_front();
        m_word = w; m_ov = 1'b1;
      end else if (ordy) begin
        m_ov = 1'b0;
      end
      if (pushm) exp_q.push_back(din);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    check("rand_count", count_a, exp_q.size());
    check("rand_full", full_a, exp_q.size() == DA);
    check("rand_empty", empty_a, exp_q.size() == 0);
    check("rand_out_valid", bus_a.out_valid, m_ov);
    check("rand_ovf", ovf_a, m_ovf);
    if (m_ov) check("rand_data_out", bus_a.data_out, m_word);
  endtask

  logic [127:0] pad_exp_data;
  logic         pad_exp_ov;
  logic [3:0]   pad_exp_cnt;
  logic [1:0]   blk_st;

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    // reset state of both instances
    check("rst_in_ready_a", bus_a.in_ready, 1'b0);
    check("rst_out_valid_a", bus_a.out_valid, 1'b0);
    check("rst_data_out_a", bus_a.data_out, '0);
    check("rst_count_a", count_a, '0);
    check("rst_full_a", full_a, 1'b0);
    check("rst_empty_a", empty_a, 1'b1);
    check("rst_ovf_a", ovf_a, 1'b0);
    check("rst_out_valid_b", bus_b.out_valid, 1'b0);
    check("rst_empty_b", empty_b, 1'b1);
    st_a = 2'b01; #1;
    check("rst_in_ready_store_a", bus_a.in_ready, 1'b1);
    st_a = 2'b00;
    rst = 1'b0;

    // residue below LANES on the 4-lane instance
    push_b(32'd5); push_b(32'd6); push_b(32'd7);
    check("pad_count_before", count_b, 4'd3);
`ifdef OSB_ZERO_PAD_EN
    pad_exp_ov = 1'b1; pad_exp_cnt = 4'd0; pad_exp_data = {32'd5, 32'd6, 32'd7, 32'd0};
`else
    pad_exp_ov = 1'b0; pad_exp_cnt = 4'd3; pad_exp_data = '0;
`endif
    st_b = 2'b10; bus_b.out_ready = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check("pad_out_valid", bus_b.out_valid, pad_exp_ov);
      check("pad_count", count_b, pad_exp_cnt);
      check("pad_empty", empty_b, pad_exp_cnt == 0);
      if (pad_exp_ov) check("pad_data_out", bus_b.data_out, pad_exp_data);
    end
    st_b = 2'b00;
    do_reset();

    // basic store/stream
    add_vec(2'b01, 1, 32'd1, 0, 1, 4'd1, 0, '0, 0);
    add_vec(2'b01, 1, 32'd2, 0, 1, 4'd2, 0, '0, 0);
    add_vec(2'b01, 1, 32'd3, 0, 1, 4'd3, 0, '0, 0);
    add_vec(2'b01, 1, 32'd4, 0, 1, 4'd4, 0, '0, 0);
    add_vec(2'b10, 0, 32'd0, 1, 0, 4'd2, 1, w2(32'd1, 32'd2), 0);
    add_vec(2'b10, 0, 32'd0, 1, 0, 4'd0, 1, w2(32'd3, 32'd4), 0);
    add_vec(2'b10, 0, 32'd0, 1, 0, 4'd0, 0, '0, 0);
    // backpressure
    for (int k = 0; k < 4; k++) add_vec(2'b01, 1, 32'h10 + k, 0, 1, 4'(k + 1), 0, '0, 0);
    add_vec(2'b10, 0, 32'd0, 0, 0, 4'd2, 1, w2(32'h10, 32'h11), 0);
    for (int k = 0; k < 5; k++) add_vec(2'b10, 0, 32'd0, 0, 0, 4'd2, 1, w2(32'h10, 32'h11), 0);
    add_vec(2'b10, 0, 32'd0, 1, 0, 4'd0, 1, w2(32'h12, 32'h13), 0);
    add_vec(2'b10, 0, 32'd0, 1, 0, 4'd0, 0, '0, 0);
    // stream -> idle with a pending word
    for (int k = 0; k < 4; k++) add_vec(2'b01, 1, 32'h20 + k, 0, 1, 4'(k + 1), 0, '0, 0);
    add_vec(2'b10, 0, 32'd0, 0, 0, 4'd2, 1, w2(32'h20, 32'h21), 0);
    add_vec(2'b00, 0, 32'd0, 0, 0, 4'd2, 1, w2(32'h20, 32'h21), 0);
    add_vec(2'b00, 1, 32'h99, 1, 0, 4'd2, 0, '0, 0);
    add_vec(2'b00, 0, 32'd0, 0, 0, 4'd2, 0, '0, 0);
    add_vec(2'b10, 0, 32'd0, 1, 0, 4'd0, 1, w2(32'h22, 32'h23), 0);
    add_vec(2'b10, 0, 32'd0, 1, 0, 4'd0, 0, '0, 0);
    // fill to DEPTH, overflow, then drain through pass/stream
    for (int k = 0; k < 8; k++) add_vec(2'b01, 1, 32'h30 + k, 0, 1, 4'(k + 1), 0, '0, 0);
    add_vec(2'b01, 1, 32'h40, 0, 0, 4'd8, 0, '0, 1);
    add_vec(2'b11, 1, 32'h41, 0, 0, 4'd6, 1, w2(32'h30, 32'h31), 1);
    add_vec(2'b10, 0, 32'd0, 1, 0, 4'd4, 1, w2(32'h32, 32'h33), 1);

    foreach (tbl[k]) begin
      st_a = tbl[k].st; bus_a.in_valid = tbl[k].iv;
      bus_a.data_in = tbl[k].din; bus_a.out_ready = tbl[k].ordy;
      #1;
      check("tbl_in_ready", bus_a.in_ready, tbl[k].exp_ir);
      @(posedge clk); #1;
      check("tbl_count", count_a, tbl[k].exp_cnt);
      check("tbl_full", full_a, tbl[k].exp_cnt == 4'd8);
      check("tbl_empty", empty_a, tbl[k].exp_cnt == 4'd0);
      check("tbl_out_valid", bus_a.out_valid, tbl[k].exp_ov);
      check("tbl_ovf", ovf_a, tbl[k].exp_ovf);
      if (tbl[k].exp_ov) check("tbl_data_out", bus_a.data_out, tbl[k].exp_data);
    end

    // mid-operation reset drops the pending word and stored elements
    model_cycle(2'b10, 1'b0, '0, 1'b0, 1'b1);

    // pass mode across the 7 -> 0 pointer wrap
    for (int k = 0; k < 6; k++) model_cycle(2'b01, 1'b1, 32'h50 + k, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) model_cycle(2'b11, 1'b1, 32'h60 + k, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) model_cycle(2'b10, 1'b0, '0, 1'b1, 1'b0);

    // randomized traffic in blocks of a fixed mode
    for (int b = 0; b < 150; b++) begin
      blk_st = 2'($urandom_range(0, 3));
      for (int c = 0; c < 20; c++)
        model_cycle(blk_st, $urandom_range(0, 3) != 0, $urandom,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 299) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/operand_stream_buffer.md
# operand_stream_buffer

Parametrised successor to the single-width operand FIFO feeding the systolic array. Stores `DATA_W`-bit elements one per cycle under a valid/ready handshake. Streams them out `LANES` elements at a time as one packed word through a registered valid/ready output stage. Sits between the host/load path and the array's row/column feeders, one instance per operand channel.

## Interface
- `DATA_W`, 32: element width in bits.
- `DEPTH`, 16384: storage depth in elements; must be a power of two, ≥ 2·`LANES`.
- `LANES`, 2: elements packed per output word; must be ≥ 1 and ≤ `DEPTH`.
- `ADDR_W`, `$clog2(DEPTH)`: pointer width; derived, not overridden.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `state`  in  2  mode: 00 idle, 01 store, 10 stream, 11 pass (store and stream concurrently).
- `in_valid`  in  1  `data_in` carries an element.
- `in_ready`  out  1  buffer accepts an element this cycle.
- `data_in`  in  `DATA_W`  element to store.
- `out_valid`  out  1  `data_out` holds an unconsumed word.
- `out_ready`  in  1  downstream consumes `data_out` this cycle.
- `data_out`  out  `DATA_W*LANES`  packed word; oldest element in the most significant slice.
- `count`  out  `ADDR_W+1`  elements currently stored, excluding the output register.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `ovf`  out  1  sticky: an element was offered while full in store/pass mode.

## Operation
- Circular array of `DEPTH` elements, write pointer `wp`, read pointer `rp`, both wrap modulo `DEPTH` (natural `ADDR_W` overflow).
- Push: `in_valid && in_ready`, where `in_ready = (state==01 || state==11) && !full`. Writes `mem[wp]`, `wp+1`.
- Pop: in state 10 or 11, when `count >= LANES` and the output register is free (`!out_valid || out_ready`). Loads `data_out` with `{mem[rp], mem[rp+1], …, mem[rp+LANES-1]}` (indices modulo `DEPTH`), sets `out_valid`, `rp+LANES`.
- Pop decisions use registered `count`. A same-cycle push is not visible to that cycle's pop.
- Count update: `count + push - (pop ? LANES : 0)`. Push and pop in the same cycle are both honoured.
- `out_valid` clears on `out_ready` with no concurrent pop. `data_out` holds its value while `out_valid && !out_ready`.
- Mode changes never discard a pending output word. In idle (00) no push or pop occurs; a pending word still drains on `out_ready`.
- `ovf` sets when `in_valid && (state==01||state==11) && full`. It clears only on `rst`.
- `in_valid` outside store/pass is ignored, with no effect on `ovf`.

## Timing
- Reset values: `in_ready` follows its equation (0 in 00/10), `out_valid` 0, `data_out` 0, `count` 0, `full` 0, `empty` 1, `ovf` 0, `wp`/`rp` 0. Memory contents are not reset.
- `rst` mid-operation wins over every push/pop that cycle. Any pending output word is dropped.
- Store latency: element pushed at edge N is counted at N+1 and poppable in the cycle after N+1.
- Stream latency: pop at edge N gives `out_valid`=1 from N+1.
- Sustained throughput: one output word per cycle while `count >= LANES` and `out_ready`=1.
- `full`, `empty`, `count` are registered, consistent with each other every cycle.
- `in_ready` is combinational from `state` and `full` only. There is no path from `in_valid`/`out_ready`.

## Configuration
- `OSB_ZERO_PAD_EN` defined:
  - In state 10 (not 11), when `0 < count < LANES` and the output register is free, a final partial pop occurs.
  - The oldest `count` elements fill the upper slices and remaining lanes are zero.
  - `rp += count`, and `count` becomes 0.
- `OSB_ZERO_PAD_EN` undefined: residue below `LANES` stays stored until more elements arrive. No partial word is ever emitted.

## Test plan
- Reset, `LANES`=2: push 1,2,3,4 in store, then stream with `out_ready`=1. Required: `data_out`=`{1,2}` then `{3,4}` on consecutive cycles, then `empty`=1 and `out_valid` drops.
- `DEPTH`=8: push 8 elements. Required: `full`=1 and `in_ready`=0. Offer a 9th: `ovf`=1 and `count` stays 8.
- Backpressure: stream with `out_ready`=0 for 5 cycles. Required: `data_out` stable, `count` unchanged. Then release: next word appears one cycle later.
- Pass mode, `DEPTH`=8: after 6 pushes/3 pops crossing index 7→0, streaming continues. Required: output order equals input order across wrap, with `count` tracking exactly.
- Mode 10→00 while `out_valid`=1: word retained. Assert `out_ready`: word consumed, no new pop.
- `LANES`=4, 3 elements 5,6,7 stored, state 10. With `OSB_ZERO_PAD_EN`: `data_out`=`{5,6,7,0}` and `count`=0. Without it: `out_valid` stays 0 and `count` stays 3.
